aes_inv_cipher_iter: RTL

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_inv_round_step.sv | 37 +++
 rtl/aes_inv_cipher_iter.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: round count, inverse S-box, GF(2^8) arithmetic
// and the iterative controller state type.
package aes_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

   function automatic int unsigned nr_of(input int unsigned key_bits);
      return (key_bits == 256) ? 14 : (key_bits == 192) ? 12 : 10;
   endfunction

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_inv_round_step.sv
// One combinational inverse AES round; InvMixColumns is bypassed on the final round.
module aes_inv_round_step
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] key,
   input  logic         is_last,
   output logic [127:0] next_state
);

   logic [7:0] sb [16];
   logic [7:0] ak [16];
   logic [7:0] mc [16];

   always_comb begin
      next_state = '0;
      for (int i = 0; i < 16; i++) begin
         // Byte i sits at row i%4, column i/4; row r rotates right by r.
         sb[i] = INV_SBOX[state[127 - 8*((i % 4) + 4*(((i / 4) + 4 - (i % 4)) % 4)) -: 8]];
         ak[i] = sb[i] ^ key[127 - 8*i -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = gf_mul(ak[4*c], 8'h0e) ^ gf_mul(ak[4*c+1], 8'h0b) ^
                     gf_mul(ak[4*c+2], 8'h0d) ^ gf_mul(ak[4*c+3], 8'h09);
         mc[4*c+1] = gf_mul(ak[4*c], 8'h09) ^ gf_mul(ak[4*c+1], 8'h0e) ^
                     gf_mul(ak[4*c+2], 8'h0b) ^ gf_mul(ak[4*c+3], 8'h0d);
         mc[4*c+2] = gf_mul(ak[4*c], 8'h0d) ^ gf_mul(ak[4*c+1], 8'h09) ^
                     gf_mul(ak[4*c+2], 8'h0e) ^ gf_mul(ak[4*c+3], 8'h0b);
         mc[4*c+3] = gf_mul(ak[4*c], 8'h0b) ^ gf_mul(ak[4*c+1], 8'h0d) ^
                     gf_mul(ak[4*c+2], 8'h09) ^ gf_mul(ak[4*c+3], 8'h0e);
      end
      for (int i = 0; i < 16; i++) begin
         next_state[127 - 8*i -: 8] = is_last ? ak[i] : mc[i];
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: RPC inverse rounds per clock over an externally
// supplied, externally held round-key schedule.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter  int unsigned KEY_BITS = 128,
   parameter  int unsigned RPC      = 1,
   localparam int unsigned NR       = nr_of(KEY_BITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          in_data,
   input  logic [128*(NR+1)-1:0] round_keys,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          out_data,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(NR);
   localparam int unsigned NK = 2**CW;

   if (RPC != 1 && RPC != 2) begin : g_bad_rpc
      $error("aes_inv_cipher_iter: RPC must be 1 or 2");
   end

   fsm_e          fsm_q;
   logic [CW-1:0] ctr_q;
   logic [127:0]  state_q;
   logic [127:0]  keys  [NK];
   logic [CW-1:0] rnd   [RPC];
   logic [127:0]  chain [RPC+1];
   logic          accept;
   logic          last_cycle;

   // Pad the key table to a power of two so any counter value indexes in range.
   for (genvar i = 0; i < NK; i++) begin : g_keys
      if (i <= NR) begin : g_used
         assign keys[i] = round_keys[i*128 +: 128];
      end else begin : g_pad
         assign keys[i] = '0;
      end
   end

   assign chain[0] = state_q;

   for (genvar j = 0; j < RPC; j++) begin : g_step
      assign rnd[j] = ctr_q - CW'(j);
      aes_inv_round_step u_step (
         .state      (chain[j]),
         .key        (keys[rnd[j]]),
         .is_last    (rnd[j] == '0),
         .next_state (chain[j+1])
      );
   end

   assign in_ready   = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
   assign accept     = in_valid && in_ready;
   assign last_cycle = (ctr_q == CW'(RPC - 1));
   assign out_data   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= StIdle;
         ctr_q     <= '0;
         state_q   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (fsm_q)
            StIdle: begin
               if (accept) begin
                  state_q <= in_data ^ keys[NR];
                  ctr_q   <= CW'(NR - 1);
                  fsm_q   <= StRun;
                  busy    <= 1'b1;
               end
            end
            StRun: begin
               state_q <= chain[RPC];
               if (last_cycle) begin
                  // Park the counter at zero rather than stepping below it.
                  ctr_q     <= '0;
                  fsm_q     <= StDone;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  ctr_q <= ctr_q - CW'(RPC);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     state_q <= in_data ^ keys[NR];
                     ctr_q   <= CW'(NR - 1);
                     fsm_q   <= StRun;
                     busy    <= 1'b1;
                  end else begin
                     fsm_q <= StIdle;
                  end
               end
            end
            default: begin
               fsm_q     <= StIdle;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
